// File: rtl/note_scheduler.sv
// Autoplay note sequencer with a manual keyboard override.
// A 15-note song ROM is stepped through PLAY (note audible) and GAP
// (silence) phases. Any pressed key overrides the output note and
// freezes the autoplay timing until it is released.
module note_scheduler #(
    parameter int BEAT_CLKS = 25_000_000,
    parameter int GAP_CLKS  = 2_500_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    input  logic [7:0] sw,
    output logic [3:0] note,
    output logic       src,
    output logic       busy,
    output logic [3:0] idx,
    output logic       done
);

    // Counter must hold 2*BEAT_CLKS without wrapping.
    localparam int CW = $clog2(32'sd2 * BEAT_CLKS + 32'sd1);

    localparam logic [CW-1:0] LOAD_ONE  = CW'(BEAT_CLKS - GAP_CLKS - 32'sd1);
    localparam logic [CW-1:0] LOAD_TWO  = CW'(32'sd2 * BEAT_CLKS - GAP_CLKS - 32'sd1);
    localparam logic [CW-1:0] LOAD_GAP  = CW'((GAP_CLKS > 32'sd0) ? (GAP_CLKS - 32'sd1) : 32'sd0);
    localparam logic          HAS_GAP   = (GAP_CLKS > 32'sd0);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [3:0]    LAST_IDX  = 4'd14;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Song ROM: note code per index.
    function automatic logic [3:0] rom_note(input logic [3:0] i);
        case (i)
            4'd0, 4'd1, 4'd6, 4'd11, 4'd12: rom_note = 4'd3;
            4'd2, 4'd5:                     rom_note = 4'd4;
            4'd3, 4'd4:                     rom_note = 4'd5;
            4'd7, 4'd10, 4'd13, 4'd14:      rom_note = 4'd2;
            4'd8, 4'd9:                     rom_note = 4'd1;
            default:                        rom_note = 4'd0;
        endcase
    endfunction

    // PLAY-phase counter preload; only the final note lasts two beats.
    function automatic logic [CW-1:0] play_load(input logic [3:0] i);
        if (i == LAST_IDX) begin
            play_load = LOAD_TWO;
        end else begin
            play_load = LOAD_ONE;
        end
    endfunction

    // Highest-index pressed key wins: sw[7] -> 1 ... sw[0] -> 8.
    function automatic logic [3:0] key_code(input logic [7:0] k);
        casez (k)
            8'b1???????: key_code = 4'd1;
            8'b01??????: key_code = 4'd2;
            8'b001?????: key_code = 4'd3;
            8'b0001????: key_code = 4'd4;
            8'b00001???: key_code = 4'd5;
            8'b000001??: key_code = 4'd6;
            8'b0000001?: key_code = 4'd7;
            8'b00000001: key_code = 4'd8;
            default:     key_code = 4'd0;
        endcase
    endfunction

    logic [1:0]    state_r, state_nx_s, adv_state_s;
    logic [3:0]    idx_r, idx_nx_s, adv_idx_s;
    logic [CW-1:0] cnt_r, cnt_nx_s, adv_cnt_s;
    logic          adv_done_s, done_nx_s;
    logic [3:0]    note_r, note_nx_s;
    logic          src_r, busy_r, done_r;
    logic          sw_any_s;

    assign sw_any_s = |sw;

    // Where the song goes after the current note's timing expires.
    always_comb begin
        adv_state_s = ST_IDLE;
        adv_idx_s   = 4'd0;
        adv_cnt_s   = CNT_ZERO;
        adv_done_s  = 1'b0;
        if (idx_r >= LAST_IDX) begin
            adv_done_s = 1'b1;
            if (loop) begin
                adv_state_s = ST_PLAY;
                adv_cnt_s   = play_load(4'd0);
            end else begin
                adv_state_s = ST_IDLE;
            end
        end else begin
            adv_state_s = ST_PLAY;
            adv_idx_s   = idx_r + 4'd1;
            adv_cnt_s   = play_load(idx_r + 4'd1);
        end
    end

    // Next-state logic: stop beats start, keys freeze timing only.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        cnt_nx_s   = cnt_r;
        done_nx_s  = 1'b0;
        if (stop) begin
            state_nx_s = ST_IDLE;
            idx_nx_s   = 4'd0;
            cnt_nx_s   = CNT_ZERO;
        end else if (start && (state_r == ST_IDLE)) begin
            state_nx_s = ST_PLAY;
            idx_nx_s   = 4'd0;
            cnt_nx_s   = play_load(4'd0);
        end else if (sw_any_s) begin
            state_nx_s = state_r;
        end else begin
            case (state_r)
                ST_PLAY: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_nx_s = cnt_r - CNT_ONE;
                    end else if (HAS_GAP) begin
                        state_nx_s = ST_GAP;
                        cnt_nx_s   = LOAD_GAP;
                    end else begin
                        state_nx_s = adv_state_s;
                        idx_nx_s   = adv_idx_s;
                        cnt_nx_s   = adv_cnt_s;
                        done_nx_s  = adv_done_s;
                    end
                end
                ST_GAP: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_nx_s = cnt_r - CNT_ONE;
                    end else begin
                        state_nx_s = adv_state_s;
                        idx_nx_s   = adv_idx_s;
                        cnt_nx_s   = adv_cnt_s;
                        done_nx_s  = adv_done_s;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    idx_nx_s   = 4'd0;
                    cnt_nx_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output note: pressed key first, otherwise the ROM note while playing.
    always_comb begin
        note_nx_s = 4'd0;
        if (sw_any_s) begin
            note_nx_s = key_code(sw);
        end else if (state_nx_s == ST_PLAY) begin
            note_nx_s = rom_note(idx_nx_s);
        end else begin
            note_nx_s = 4'd0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
            idx_r   <= 4'd0;
            cnt_r   <= CNT_ZERO;
            note_r  <= 4'd0;
            src_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            cnt_r   <= cnt_nx_s;
            note_r  <= note_nx_s;
            src_r   <= sw_any_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            done_r  <= done_nx_s;
        end
    end

    assign note = note_r;
    assign src  = src_r;
    assign busy = busy_r;
    assign idx  = idx_r;
    assign done = done_r;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler with BEAT_CLKS=10, GAP_CLKS=2.
// Cycle k counts edges after the cycle in which start was pulsed.
module tb_note_scheduler;

    logic       CLK;
    logic       RESET;
    logic       start;
    logic       stop;
    logic       loop;
    logic [7:0] sw;
    logic [3:0] note;
    logic       src;
    logic       busy;
    logic [3:0] idx;
    logic       done;

    int checks = 0;
    int errors = 0;
    int song [15] = '{3, 3, 4, 5, 5, 4, 3, 2, 1, 1, 2, 3, 3, 2, 2};

    note_scheduler #(.BEAT_CLKS(10), .GAP_CLKS(2)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .stop(stop), .loop(loop),
        .sw(sw), .note(note), .src(src), .busy(busy), .idx(idx), .done(done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Expected {note, idx, busy, done} at cycle k of a song run.
    function automatic logic [9:0] exp_vec(input int k, input logic lp);
        int i;
        int off;
        logic [3:0] n;
        if (k <= 140) begin
            i   = (k - 1) / 10;
            off = (k - 1) % 10;
            n   = (off < 8) ? 4'(song[i]) : 4'd0;
            return {n, 4'(i), 1'b1, 1'b0};
        end else if (k <= 160) begin
            off = k - 141;
            n   = (off < 18) ? 4'd2 : 4'd0;
            return {n, 4'd14, 1'b1, 1'b0};
        end else if (lp) begin
            return {4'd3, 4'd0, 1'b1, 1'b1};
        end else begin
            return {4'd0, 4'd0, 1'b0, 1'b1};
        end
    endfunction

    task automatic test_reset;
        RESET = 1'b0;
        #3;
        checks++;
        if ({note, src, busy, idx, done} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state got=%h want=000", {note, src, busy, idx, done});
        end
        repeat (2) tick();
        RESET = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({note, busy, idx, done} !== 10'd0) begin
                errors++;
                $display("FAIL idle_after_reset c=%0d got=%h want=000", c, {note, busy, idx, done});
            end
        end
    endtask

    task automatic test_start_timing;
        logic [3:0] exp_n;
        pulse_start();
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) tick();
            if (k == 5) start = 1'b1;
            if (k == 6) start = 1'b0;
            exp_n = (k <= 8) ? 4'd3 : ((k <= 10) ? 4'd0 : 4'd3);
            checks++;
            if (note !== exp_n || busy !== 1'b1 || src !== 1'b0) begin
                errors++;
                $display("FAIL start_timing k=%0d note=%0d busy=%b src=%b want note=%0d busy=1 src=0",
                         k, note, busy, src, exp_n);
            end
        end
        checks++;
        if (idx !== 4'd1) begin
            errors++;
            $display("FAIL start_idx1 got=%0d want=1", idx);
        end
        do_stop();
    endtask

    task automatic run_song(input logic lp);
        logic [9:0] exp;
        loop = lp;
        pulse_start();
        for (int k = 1; k <= 162; k++) begin
            if (k > 1) tick();
            exp = (k <= 161) ? exp_vec(k, lp)
                             : (lp ? {4'd3, 4'd0, 1'b1, 1'b0} : 10'd0);
            checks++;
            if ({note, idx, busy, done} !== exp) begin
                errors++;
                $display("FAIL song loop=%b k=%0d got note=%0d idx=%0d busy=%b done=%b want note=%0d idx=%0d busy=%b done=%b",
                         lp, k, note, idx, busy, done, exp[9:6], exp[5:2], exp[1], exp[0]);
            end
        end
        do_stop();
        loop = 1'b0;
    endtask

    task automatic test_full_song;
        run_song(1'b0);
    endtask

    task automatic test_reset_mid_song;
        pulse_start();
        repeat (52) tick();
        checks++;
        if (idx !== 4'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_song_pos idx=%0d busy=%b want idx=5 busy=1", idx, busy);
        end
        RESET = 1'b0;
        #2;
        checks++;
        if (note !== 4'd0 || busy !== 1'b0 || idx !== 4'd0) begin
            errors++;
            $display("FAIL async_reset note=%0d busy=%b idx=%0d want 0 0 0", note, busy, idx);
        end
        #1;
        RESET = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if ({note, busy, idx, done} !== 10'd0) begin
                errors++;
                $display("FAIL post_reset_quiet c=%0d got=%h want=000", c, {note, busy, idx, done});
            end
        end
    endtask

    task automatic test_sw_override;
        logic [3:0] exp_n;
        logic       exp_s;
        logic [3:0] exp_i;
        pulse_start();
        repeat (22) tick();
        sw = 8'b0001_0000;
        for (int k = 24; k <= 36; k++) begin
            tick();
            if (k == 28) sw = 8'd0;
            if (k <= 28) begin
                exp_n = 4'd4; exp_s = 1'b1; exp_i = 4'd2;
            end else if (k <= 33) begin
                exp_n = 4'd4; exp_s = 1'b0; exp_i = 4'd2;
            end else if (k <= 35) begin
                exp_n = 4'd0; exp_s = 1'b0; exp_i = 4'd2;
            end else begin
                exp_n = 4'd5; exp_s = 1'b0; exp_i = 4'd3;
            end
            checks++;
            if (note !== exp_n || src !== exp_s || idx !== exp_i || busy !== 1'b1) begin
                errors++;
                $display("FAIL sw_override k=%0d note=%0d src=%b idx=%0d busy=%b want note=%0d src=%b idx=%0d busy=1",
                         k, note, src, idx, busy, exp_n, exp_s, exp_i);
            end
        end
        do_stop();
    endtask

    task automatic test_start_stop_together;
        pulse_start();
        repeat (62) tick();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({note, busy, idx, done} !== 10'd0) begin
                errors++;
                $display("FAIL start_stop_idle c=%0d got=%h want=000", c, {note, busy, idx, done});
            end
            tick();
        end
        pulse_start();
        checks++;
        if (note !== 4'd3 || idx !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart note=%0d idx=%0d busy=%b want 3 0 1", note, idx, busy);
        end
        repeat (10) tick();
        checks++;
        if (note !== 4'd3 || idx !== 4'd1) begin
            errors++;
            $display("FAIL restart_adv note=%0d idx=%0d want 3 1", note, idx);
        end
        do_stop();
    endtask

    task automatic test_loop;
        run_song(1'b1);
        sw = 8'b1000_0001;
        tick();
        checks++;
        if (note !== 4'd1 || src !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_keys note=%0d src=%b busy=%b want 1 1 0", note, src, busy);
        end
        sw = 8'b0000_0001;
        tick();
        checks++;
        if (note !== 4'd8 || src !== 1'b1) begin
            errors++;
            $display("FAIL key_c5 note=%0d src=%b want 8 1", note, src);
        end
        sw = 8'd0;
        tick();
        checks++;
        if (note !== 4'd0 || src !== 1'b0) begin
            errors++;
            $display("FAIL key_release note=%0d src=%b want 0 0", note, src);
        end
    endtask

    initial begin
        start = 1'b0;
        stop  = 1'b0;
        loop  = 1'b0;
        sw    = 8'd0;
        test_reset();
        test_start_timing();
        test_full_song();
        test_reset_mid_song();
        test_sw_override();
        test_start_stop_together();
        test_loop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 SHALL have parameter BEAT_CLKS, default 25_000_000, clock cycles per beat (>= 2).
REQ-002 SHALL have parameter GAP_CLKS, default 2_500_000, silent cycles ending each note (0 <= GAP_CLKS < BEAT_CLKS).
REQ-003 SHALL have port CLK  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse, begin autoplay from index 0.
REQ-006 SHALL have port stop  input  1  single-cycle pulse, abort autoplay.
REQ-007 SHALL have port loop  input  1  level; 1 = restart song after the last note.
REQ-008 SHALL have port sw  input  8  manual keys (synchronized): sw[7]=C4 ... sw[0]=C5.
REQ-009 SHALL have port note  output  4  registered note code: 0 silence, 1 C4, 2 D, 3 E, 4 F, 5 G, 6 A, 7 B, 8 C5.
REQ-010 SHALL have port src  output  1  registered; 1 = note comes from sw, 0 = from autoplay.
REQ-011 SHALL have port busy  output  1  1 while in PLAY or GAP.
REQ-012 SHALL have port idx  output  4  current song index, 0..14.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the song finishes.

Function
REQ-014 SHALL contain a 15-entry song ROM with notes 3,3,4,5,5,4,3,2,1,1,2,3,3,2,2 and durations of 1 beat at indices 0-13 and 2 beats at index 14.
REQ-015 SHALL implement states IDLE, PLAY and GAP; a done pulse is issued on the transition out of the last GAP.
REQ-016 In IDLE, start SHALL move the block to PLAY with idx=0, and note=ROM[0] SHALL appear in the following cycle.
REQ-017 In PLAY, note SHALL equal ROM[idx] for dur*BEAT_CLKS-GAP_CLKS cycles; the block SHALL then enter GAP.
REQ-018 In GAP, note SHALL be 0 for GAP_CLKS cycles; the block SHALL then enter PLAY at idx+1; if GAP_CLKS=0, GAP SHALL be skipped.
REQ-019 After the GAP of idx 14 with loop=0, the block SHALL go to IDLE, set idx=0, note=0 and pulse done=1 for one cycle, in the same cycle that busy falls.
REQ-020 After the GAP of idx 14 with loop=1, the block SHALL pulse done for one cycle and enter PLAY at idx 0 with no extra cycles.
REQ-021 stop SHALL force IDLE, idx=0 and note=0 on the next edge from any state; when stop and start occur in the same cycle, stop SHALL win; stop SHALL NOT generate done.
REQ-022 start while busy SHALL be ignored.
REQ-023 If any sw bit is 1, note SHALL equal the code of the highest-index set bit on the next edge (sw[7] maps to 1, sw[0] maps to 8), and src SHALL be 1, in any state.
REQ-024 While sw is nonzero, the state, idx and duration counter SHALL hold; after release, autoplay SHALL resume with the remaining cycles of the interrupted note or gap, with src=0 on the next edge.
REQ-025 start and stop SHALL still be honoured while sw is nonzero; only the autoplay timing freezes.
REQ-026 The duration counter SHALL be wide enough for 2*BEAT_CLKS without overflow; no wrap-around is permitted.

Reset
REQ-027 On RESET=0, the block SHALL asynchronously enter IDLE with note=0, src=0, busy=0, idx=0, done=0 and the counter cleared, including in the middle of a song.
REQ-028 After RESET rises, the block SHALL remain in IDLE until a start pulse arrives.

Verification (BEAT_CLKS=10, GAP_CLKS=2)
REQ-029 The bench SHALL pulse RESET low mid-song at idx 5 and check that note=0, busy=0 and idx=0 immediately, with no activity after release.
REQ-030 The bench SHALL pulse start at cycle T and check note=3 for T+1..T+8, note=0 for T+9..T+10, note=3 with idx=1 at T+11, and busy=1 from T+1.
REQ-031 The bench SHALL run the full song with loop=0 and check that idx 14 plays note=2 for 18 cycles then 0 for 2, and that done=1 and busy=0 only at T+161.
REQ-032 The bench SHALL set sw=8'b0001_0000 for 5 cycles during cycle 3 of idx 2 and check note=4 and src=1 one cycle later, that idx stays 2, and that after release note=4 (ROM) resumes for the remaining 5 PLAY cycles.
REQ-033 The bench SHALL apply start and stop together at idx 6 and check that the block is in IDLE with note=0, idx=0 and no done; it SHALL then apply a single start and check that the song restarts at idx 0.
REQ-034 The bench SHALL set loop=1 and check that done pulses at T+161 while busy stays 1 and note=3 with idx=0 on the same cycle; it SHALL also set sw=8'b1000_0001 in IDLE and check note=1.
